input_port_rc: RTL and testbench
================================

INPUT_PORT_RC -- requirements
Module: input_port_rc

Interface
REQ-001 SHALL have parameter FLIT_W, default 16, flit width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO depth in flits (power of 2, >=2).
REQ-003 SHALL have parameter CUR_X, default 0, this router's X coordinate (0..3).
REQ-004 SHALL have parameter CUR_Y, default 0, this router's Y coordinate (0..1).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port in_valid, input, 1, upstream flit valid.
REQ-008 SHALL have port in_ready, output, 1, FIFO can accept a flit.
REQ-009 SHALL have port in_flit, input, FLIT_W, flit: [FLIT_W-1] tail, [FLIT_W-2] head, [FLIT_W-3:FLIT_W-4] dest X, [FLIT_W-5] dest Y.
REQ-010 SHALL have port port_dst, output, 3, requested output port for the allocator.
REQ-011 SHALL have port port_en, output, 1, one-cycle strobe: port_dst changed.
REQ-012 SHALL have port sw_grant, input, 1, allocator grant: forward one flit this cycle.
REQ-013 SHALL have port out_flit, output, FLIT_W, flit toward crossbar.
REQ-014 SHALL have port out_valid, output, 1, out_flit valid.
REQ-015 SHALL have port err_drop, output, 1, one-cycle strobe: non-head flit dropped in IDLE.

Function
REQ-016 port_dst encoding SHALL be 3'b000 EMPTY, 3'b001 LOCAL, 3'b010 X1, 3'b011 X2, 3'b100 Y1.
REQ-017 FIFO: push when in_valid && in_ready; in_ready SHALL be (count < DEPTH) from registered count; full FIFO deasserts in_ready even on a pop cycle.
REQ-018 Pointers SHALL wrap modulo DEPTH; count range 0..DEPTH, +1 on push only, -1 on pop only, unchanged on both.
REQ-019 States SHALL be IDLE and ACTIVE.
REQ-020 IDLE, FIFO non-empty, front flit head bit=1: port_dst <= XY route, port_en <= 1 for one cycle, go ACTIVE; front flit not popped.
REQ-021 XY route SHALL be: destX>CUR_X -> X1; destX<CUR_X -> X2; else destY!=CUR_Y -> Y1; else LOCAL.
REQ-022 IDLE, FIFO non-empty, front head bit=0: pop and discard, err_drop=1 for one cycle, stay IDLE.
REQ-023 ACTIVE, sw_grant=1, FIFO non-empty: pop front; next cycle out_flit=popped flit, out_valid=1.
REQ-024 out_valid SHALL be 0 in every cycle not following a pop of REQ-023; out_flit holds last value.
REQ-025 ACTIVE pop of a flit with tail bit=1 (including head+tail single-flit packet): port_dst <= EMPTY, port_en=1 next cycle, go IDLE.
REQ-026 sw_grant SHALL be ignored in IDLE or with FIFO empty.
REQ-027 Latency: head flit accepted cycle t -> port_dst/port_en valid cycle t+2; grant cycle g -> out_valid cycle g+1.
REQ-028 New packet route SHALL be computed no earlier than the cycle after returning to IDLE.

Reset
REQ-029 rst=1 at a clock edge SHALL set state IDLE, count 0, pointers 0, port_dst EMPTY, port_en 0, out_valid 0, out_flit 0, err_drop 0; FIFO contents discarded.
REQ-030 rst mid-packet SHALL abandon the packet without port_en pulse; in_ready=0 during reset, 1 the cycle after.

Verification
REQ-031 CUR=(1,0), head flit destX=3,destY=0 pushed cycle 0 -> port_dst=3'b010, port_en=1 at cycle 2.
REQ-032 CUR=(1,0), single flit head+tail destX=1,destY=1, sw_grant held -> port_dst=Y1, out_valid one cycle with that flit, port_dst=EMPTY with port_en pulse.
REQ-033 Push 5 flits back-to-back, no grant, DEPTH=4 -> in_ready=0 after 4th accepted, 5th held upstream.
REQ-034 Body flit (head=0,tail=0) arrives in IDLE -> err_drop=1 one cycle, count returns to 0, port_en stays 0.
REQ-035 3-flit packet, sw_grant toggled 1,0,1,1 -> out_valid 1,0,1,1 one cycle later; IDLE after tail.
REQ-036 rst asserted while ACTIVE with 2 flits buffered -> next cycle port_dst=EMPTY, count 0, out_valid 0.

Source files
------------

// File: rtl/input_port_rc.sv
// Router input port: flit FIFO, XY route computation and a two-state packet
// controller. The head flit at the FIFO front selects an output port. Granted
// flits are forwarded to the crossbar. A tail flit releases the port.
module input_port_rc #(
  parameter int FLIT_W = 16,
  parameter int DEPTH  = 4,
  parameter int CUR_X  = 0,
  parameter int CUR_Y  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FLIT_W-1:0] in_flit,
  output logic [2:0]        port_dst,
  output logic              port_en,
  input  logic              sw_grant,
  output logic [FLIT_W-1:0] out_flit,
  output logic              out_valid,
  output logic              err_drop
);

  localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [1:0] CUR_X_C = 2'(CUR_X);
  localparam logic       CUR_Y_C = 1'(CUR_Y);

  localparam logic [2:0] DST_EMPTY = 3'b000;
  localparam logic [2:0] DST_LOCAL = 3'b001;
  localparam logic [2:0] DST_X1    = 3'b010;
  localparam logic [2:0] DST_X2    = 3'b011;
  localparam logic [2:0] DST_Y1    = 3'b100;

  typedef enum logic {IDLE, ACTIVE} state_e;

  state_e            state_q, state_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [2:0]        port_dst_q, port_dst_d;
  logic              port_en_q, port_en_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;
  logic              out_valid_q, out_valid_d;
  logic              err_drop_q, err_drop_d;

  logic              push;
  logic              pop;
  logic              empty;
  logic [FLIT_W-1:0] front;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  function automatic logic [2:0] xy_route(input logic [1:0] dx, input logic dy);
    if (dx > CUR_X_C)      return DST_X1;
    else if (dx < CUR_X_C) return DST_X2;
    else if (dy != CUR_Y_C) return DST_Y1;
    else                   return DST_LOCAL;
  endfunction

  // Readiness comes from the registered count only, so a full FIFO refuses
  // a flit even in a cycle where it is also popping.
  assign in_ready = ~rst & (count_q < DEPTH_C);
  assign push     = in_valid & in_ready;
  assign empty    = (count_q == '0);
  assign front    = mem_q[rd_ptr_q];

  // Next-state for the packet controller, FIFO pointers and registered outputs.
  always_comb begin
    state_d     = state_q;
    port_dst_d  = port_dst_q;
    port_en_d   = 1'b0;
    out_flit_d  = out_flit_q;
    out_valid_d = 1'b0;
    err_drop_d  = 1'b0;
    pop         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!empty) begin
          if (front[FLIT_W-2]) begin
            // Head flit stays in the FIFO; it is forwarded once granted.
            port_dst_d = xy_route(front[FLIT_W-3:FLIT_W-4], front[FLIT_W-5]);
            port_en_d  = 1'b1;
            state_d    = ACTIVE;
          end else begin
            // Orphan body/tail flit with no open packet: discard it.
            pop        = 1'b1;
            err_drop_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (sw_grant && !empty) begin
          pop         = 1'b1;
          out_flit_d  = front;
          out_valid_d = 1'b1;
          if (front[FLIT_W-1]) begin
            port_dst_d = DST_EMPTY;
            port_en_d  = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      port_dst_q  <= DST_EMPTY;
      port_en_q   <= 1'b0;
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      port_dst_q  <= port_dst_d;
      port_en_q   <= port_en_d;
      out_flit_q  <= out_flit_d;
      out_valid_q <= out_valid_d;
      err_drop_q  <= err_drop_d;
    end
  end

  // Flit storage; stale entries are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_flit;
    end
  end

  assign port_dst  = port_dst_q;
  assign port_en   = port_en_q;
  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;
  assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_input_port_rc.sv
// Directed bench for input_port_rc with the router placed at (1,0).
module tb_input_port_rc;

  localparam int FW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_flit;
  logic [2:0]    port_dst;
  logic          port_en;
  logic          sw_grant;
  logic [FW-1:0] out_flit;
  logic          out_valid;
  logic          err_drop;

  int n_cmp = 0;
  int n_err = 0;

  input_port_rc #(.FLIT_W(FW), .DEPTH(4), .CUR_X(1), .CUR_Y(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_flit(in_flit), .port_dst(port_dst), .port_en(port_en),
    .sw_grant(sw_grant), .out_flit(out_flit), .out_valid(out_valid),
    .err_drop(err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          iv;
    logic [FW-1:0] flit;
    logic          gnt;
    logic          rdy;
    logic [2:0]    dst;
    logic          en;
    logic          ov;
    logic [FW-1:0] of;
    logic          ed;
  } vec_t;

  vec_t tbl [27];

  function automatic logic [FW-1:0] mk(input logic tl, input logic hd,
                                       input logic [1:0] dx, input logic dy,
                                       input logic [10:0] pay);
    return {tl, hd, dx, dy, pay};
  endfunction

  function automatic vec_t v(input logic r, input logic iv, input logic [FW-1:0] f,
                             input logic g, input logic rdy, input logic [2:0] dst,
                             input logic en, input logic ov, input logic [FW-1:0] of,
                             input logic ed);
    vec_t t;
    t.rst = r; t.iv = iv; t.flit = f; t.gnt = g; t.rdy = rdy;
    t.dst = dst; t.en = en; t.ov = ov; t.of = of; t.ed = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [FW-1:0] f, input logic g);
    rst = r; in_valid = iv; in_flit = f; sw_grant = g;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [FW-1:0] ha, ba, s1, b0, f1, f2, f3, f4, f5;
  logic [FW-1:0] p1, p2, p3, q1, q2;

  initial begin
    ha = mk(1'b0, 1'b1, 2'd3, 1'b0, 11'd1);
    ba = mk(1'b1, 1'b0, 2'd0, 1'b0, 11'd2);
    s1 = mk(1'b1, 1'b1, 2'd1, 1'b1, 11'd3);
    b0 = mk(1'b0, 1'b0, 2'd2, 1'b0, 11'd4);
    f1 = mk(1'b0, 1'b1, 2'd0, 1'b0, 11'd5);
    f2 = mk(1'b0, 1'b0, 2'd0, 1'b0, 11'd6);
    f3 = mk(1'b0, 1'b0, 2'd0, 1'b0, 11'd7);
    f4 = mk(1'b0, 1'b0, 2'd0, 1'b0, 11'd8);
    f5 = mk(1'b1, 1'b0, 2'd0, 1'b0, 11'd9);
    p1 = mk(1'b0, 1'b1, 2'd1, 1'b0, 11'd10);
    p2 = mk(1'b0, 1'b0, 2'd0, 1'b0, 11'd11);
    p3 = mk(1'b1, 1'b0, 2'd0, 1'b0, 11'd12);
    q1 = mk(1'b0, 1'b1, 2'd2, 1'b0, 11'd13);
    q2 = mk(1'b0, 1'b0, 2'd0, 1'b0, 11'd14);

    //            rst iv  flit gnt | rdy dst en ov of  ed
    // reset
    tbl[0]  = v(1, 0, '0, 0,  0, 3'd0, 0, 0, '0, 0);
    // head to X=3 from X=1: route X1 two cycles after push, then body+tail
    tbl[1]  = v(0, 1, ha, 0,  1, 3'd0, 0, 0, '0, 0);
    tbl[2]  = v(0, 0, '0, 0,  1, 3'd2, 1, 0, '0, 0);
    tbl[3]  = v(0, 1, ba, 1,  1, 3'd2, 0, 1, ha, 0);
    tbl[4]  = v(0, 0, '0, 1,  1, 3'd0, 1, 1, ba, 0);
    tbl[5]  = v(0, 0, '0, 0,  1, 3'd0, 0, 0, ba, 0);
    // single-flit packet to (1,1): Y1, grant held (ignored while IDLE)
    tbl[6]  = v(0, 1, s1, 1,  1, 3'd0, 0, 0, ba, 0);
    tbl[7]  = v(0, 0, '0, 1,  1, 3'd4, 1, 0, ba, 0);
    tbl[8]  = v(0, 0, '0, 1,  1, 3'd0, 1, 1, s1, 0);
    tbl[9]  = v(0, 0, '0, 1,  1, 3'd0, 0, 0, s1, 0);
    // orphan body flit dropped in IDLE
    tbl[10] = v(0, 1, b0, 0,  1, 3'd0, 0, 0, s1, 0);
    tbl[11] = v(0, 0, '0, 0,  1, 3'd0, 0, 0, s1, 1);
    tbl[12] = v(0, 0, '0, 0,  1, 3'd0, 0, 0, s1, 0);
    // five back-to-back flits, no grant: fifth held while full
    tbl[13] = v(0, 1, f1, 0,  1, 3'd0, 0, 0, s1, 0);
    tbl[14] = v(0, 1, f2, 0,  1, 3'd3, 1, 0, s1, 0);
    tbl[15] = v(0, 1, f3, 0,  1, 3'd3, 0, 0, s1, 0);
    tbl[16] = v(0, 1, f4, 0,  1, 3'd3, 0, 0, s1, 0);
    tbl[17] = v(0, 1, f5, 0,  0, 3'd3, 0, 0, s1, 0);
    tbl[18] = v(0, 1, f5, 1,  0, 3'd3, 0, 1, f1, 0);
    tbl[19] = v(0, 1, f5, 0,  1, 3'd3, 0, 0, f1, 0);
    tbl[20] = v(0, 0, '0, 1,  0, 3'd3, 0, 1, f2, 0);
    tbl[21] = v(0, 0, '0, 0,  1, 3'd3, 0, 0, f2, 0);
    tbl[22] = v(0, 0, '0, 1,  1, 3'd3, 0, 1, f3, 0);
    tbl[23] = v(0, 0, '0, 0,  1, 3'd3, 0, 0, f3, 0);
    tbl[24] = v(0, 0, '0, 1,  1, 3'd3, 0, 1, f4, 0);
    tbl[25] = v(0, 0, '0, 1,  1, 3'd0, 1, 1, f5, 0);
    tbl[26] = v(0, 0, '0, 0,  1, 3'd0, 0, 0, f5, 0);

    for (int i = 0; i < 27; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].flit, tbl[i].gnt);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
      step();
      chk($sformatf("row%0d port_dst", i),  32'(port_dst),  32'(tbl[i].dst));
      chk($sformatf("row%0d port_en", i),   32'(port_en),   32'(tbl[i].en));
      chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("row%0d out_flit", i),  32'(out_flit),  32'(tbl[i].of));
      chk($sformatf("row%0d err_drop", i),  32'(err_drop),  32'(tbl[i].ed));
    end

    // Three-flit packet to the local port, grant pattern 1,0,1,1.
    drive(0, 1, p1, 0); step();
    chk("pkt3 route early", 32'(port_en), 32'd0);
    drive(0, 1, p2, 0); step();
    chk("pkt3 dst", 32'(port_dst), 32'd1);
    chk("pkt3 en",  32'(port_en),  32'd1);
    drive(0, 1, p3, 0); step();
    chk("pkt3 en one cycle", 32'(port_en), 32'd0);
    drive(0, 0, '0, 1); step();
    chk("pkt3 g1 ov", 32'(out_valid), 32'd1);
    chk("pkt3 g1 of", 32'(out_flit),  32'(p1));
    drive(0, 0, '0, 0); step();
    chk("pkt3 g0 ov", 32'(out_valid), 32'd0);
    chk("pkt3 g0 of", 32'(out_flit),  32'(p1));
    drive(0, 0, '0, 1); step();
    chk("pkt3 g2 ov", 32'(out_valid), 32'd1);
    chk("pkt3 g2 of", 32'(out_flit),  32'(p2));
    drive(0, 0, '0, 1); step();
    chk("pkt3 g3 ov",  32'(out_valid), 32'd1);
    chk("pkt3 g3 of",  32'(out_flit),  32'(p3));
    chk("pkt3 release dst", 32'(port_dst), 32'd0);
    chk("pkt3 release en",  32'(port_en),  32'd1);

    // Back in IDLE: a new head routes, then reset while ACTIVE with 2 buffered.
    drive(0, 1, q1, 0); step();
    chk("q head en early", 32'(port_en), 32'd0);
    chk("q head ov",       32'(out_valid), 32'd0);
    drive(0, 1, q2, 0); step();
    chk("q dst", 32'(port_dst), 32'd2);
    chk("q en",  32'(port_en),  32'd1);
    drive(1, 0, '0, 1);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd0);
    step();
    chk("rst dst",      32'(port_dst),  32'd0);
    chk("rst en",       32'(port_en),   32'd0);
    chk("rst ov",       32'(out_valid), 32'd0);
    chk("rst of",       32'(out_flit),  32'd0);
    drive(0, 0, '0, 1);
    #1;
    chk("post-rst in_ready", 32'(in_ready), 32'd1);
    step();
    chk("post-rst en",  32'(port_en),   32'd0);
    chk("post-rst dst", 32'(port_dst),  32'd0);
    chk("post-rst ov",  32'(out_valid), 32'd0);
    drive(0, 0, '0, 0); step();
    chk("post-rst ed",  32'(err_drop),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
